mem_stage: RTL and testbench

- Memory-access stage of the 5-stage core. Sits between ex_mem_reg and wb_stage.
- Issues Dcache load/store requests with a valid/ready handshake and performs store byte-lane alignment.
- Holds a request that the Dcache has not yet accepted, and stalls the pipeline via fc while it does.
- Contains the mem_wb pipeline register that feeds wb_stage. Load data bypasses this stage: Dcache returns it right-aligned directly to wb_stage.

---
 rtl/core_pkg.sv | 49 ++++
 rtl/mem_stage_if.sv | 15 +
 rtl/mem_store_align.sv | 37 +++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: memory-op / width encodings, mem-stage FSM states,
// the Dcache request payload and the access-alignment rule.
package core_pkg;

    localparam int unsigned CORE_ADDR_W = 32;
    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_BE_W   = CORE_DATA_W / 8;
    localparam int unsigned REG_ADDR_W  = 5;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        WIDTH_B    = 2'b00,
        WIDTH_H    = 2'b01,
        WIDTH_W    = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Dcache request payload, also the layout of the held request while BUSY
    typedef struct packed {
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
        logic [CORE_BE_W-1:0]   be;
    } dreq_t;

    // Natural alignment check; the reserved width never counts as aligned
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            WIDTH_B: mis = 1'b0;
            WIDTH_H: mis = addr_lo[0];
            WIDTH_W: mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Dcache request/ready handshake between mem_stage (master) and the Dcache (slave).
interface mem_stage_if;
    import core_pkg::*;

    logic                   req;
    logic                   we;
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] wdata;
    logic [CORE_BE_W-1:0]   be;
    logic                   ready;

    modport master (output req, we, addr, wdata, be, input ready);
    modport slave  (input req, we, addr, wdata, be, output ready);

endinterface

// File: rtl/mem_store_align.sv
// Store byte-lane alignment: replicates store data across lanes, builds byte
// enables from the low address bits and flags misaligned accesses.
module mem_store_align
    import core_pkg::*;
(
    input  logic [1:0]             i_width,
    input  logic [1:0]             i_addr_lo,
    input  logic [CORE_DATA_W-1:0] i_op_b,
    output logic [CORE_BE_W-1:0]   o_be,
    output logic [CORE_DATA_W-1:0] o_wdata,
    output logic                   o_misaligned
);

    // Lane steering per access width
    always_comb begin
        o_be         = '0;
        o_wdata      = i_op_b;
        o_misaligned = is_misaligned(i_width, i_addr_lo);
        case (i_width)
            WIDTH_B: begin
                o_be    = CORE_BE_W'(4'b0001 << i_addr_lo);
                o_wdata = {4{i_op_b[7:0]}};
            end
            WIDTH_H: begin
                o_be    = CORE_BE_W'(4'b0011 << i_addr_lo);
                o_wdata = {2{i_op_b[15:0]}};
            end
            WIDTH_W: begin
                o_be    = '1;
            end
            default: begin
                o_be    = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues Dcache requests with a valid/ready handshake,
// holds an unaccepted request (stalling the pipe), and owns the mem_wb register.
module mem_stage
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = CORE_ADDR_W,
    parameter int unsigned DATA_W = CORE_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_mem_reg_valid_i,
    input  logic [ADDR_W-1:0]     ex_mem_reg_op_c_i,
    input  logic [DATA_W-1:0]     ex_mem_reg_op_b_i,
    input  logic [REG_ADDR_W-1:0] ex_mem_reg_reg_waddr_i,
    input  logic                  ex_mem_reg_reg_we_i,
    input  logic [1:0]            ex_mem_reg_mem_op_i,
    input  logic [1:0]            ex_mem_reg_width_i,
    input  logic                  fc_stall_i,
    input  logic                  fc_flush_i,
    mem_stage_if.master           dc,
    output logic                  mem_stall_o,
    output logic                  mem_misalign_o,
    output logic [ADDR_W-1:0]     mem_wb_reg_op_c_o,
    output logic [REG_ADDR_W-1:0] mem_wb_reg_reg_waddr_o,
    output logic                  mem_wb_reg_reg_we_o,
    output logic                  mem_wb_reg_mtype_o,
    output logic [1:0]            mem_wb_reg_width_o
);

    state_e                r_state;
    dreq_t                 r_req;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic                  r_reg_we;
    logic                  r_mtype;
    logic [1:0]            r_width;
    // Instruction flushed while its request was still outstanding
    logic                  r_kill;
    // Access of the current instruction already completed under fc stall
    logic                  r_done;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_mem_access;
    logic                  w_misaligned;
    logic                  w_mis_access;
    logic                  w_idle;
    logic                  w_idle_req;
    logic [CORE_BE_W-1:0]  w_align_be;
    logic [CORE_DATA_W-1:0] w_align_wdata;
    dreq_t                 w_idle_dreq;

    mem_store_align u_align (
        .i_width      (ex_mem_reg_width_i),
        .i_addr_lo    (ex_mem_reg_op_c_i[1:0]),
        .i_op_b       (ex_mem_reg_op_b_i),
        .o_be         (w_align_be),
        .o_wdata      (w_align_wdata),
        .o_misaligned (w_misaligned)
    );

    // Decode the instruction in ex_mem_reg; reset masks any request
    always_comb begin
        w_is_load    = (ex_mem_reg_mem_op_i == MEM_OP_LOAD);
        w_is_store   = (ex_mem_reg_mem_op_i == MEM_OP_STORE);
        w_mem_access = ex_mem_reg_valid_i & (w_is_load | w_is_store);
        w_mis_access = w_mem_access & w_misaligned;
        w_idle       = (r_state == IDLE);
        w_idle_req   = rst_n & w_idle & ~r_done & w_mem_access & ~w_misaligned & ~fc_flush_i;
        mem_misalign_o = rst_n & w_idle & ~r_done & w_mis_access & ~fc_flush_i;

        w_idle_dreq.we    = w_is_store;
        w_idle_dreq.addr  = ex_mem_reg_op_c_i;
        w_idle_dreq.wdata = w_align_wdata;
        w_idle_dreq.be    = w_is_store ? w_align_be : '0;
    end

    // Dcache request mux: live request in IDLE, held request in BUSY
    always_comb begin
        dc.req      = 1'b0;
        dc.we       = 1'b0;
        dc.addr     = '0;
        dc.wdata    = '0;
        dc.be       = '0;
        mem_stall_o = 1'b0;
        if (r_state == BUSY) begin
            dc.req      = 1'b1;
            dc.we       = r_req.we;
            dc.addr     = r_req.addr;
            dc.wdata    = r_req.wdata;
            dc.be       = r_req.be;
            mem_stall_o = ~dc.ready;
        end else begin
            dc.req      = w_idle_req;
            dc.we       = w_idle_dreq.we;
            dc.addr     = w_idle_dreq.addr;
            dc.wdata    = w_idle_dreq.wdata;
            dc.be       = w_idle_dreq.be;
            mem_stall_o = w_idle_req & ~dc.ready;
        end
    end

    // FSM, request holding registers and the mem_wb pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                <= IDLE;
            r_req                  <= '0;
            r_waddr                <= '0;
            r_reg_we               <= 1'b0;
            r_mtype                <= 1'b0;
            r_width                <= '0;
            r_kill                 <= 1'b0;
            r_done                 <= 1'b0;
            mem_wb_reg_op_c_o      <= '0;
            mem_wb_reg_reg_waddr_o <= '0;
            mem_wb_reg_reg_we_o    <= 1'b0;
            mem_wb_reg_mtype_o     <= 1'b0;
            mem_wb_reg_width_o     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_req) begin
                        r_req    <= w_idle_dreq;
                        r_waddr  <= ex_mem_reg_reg_waddr_i;
                        r_reg_we <= ex_mem_reg_reg_we_i;
                        r_mtype  <= w_is_load;
                        r_width  <= ex_mem_reg_width_i;
                        r_kill   <= 1'b0;
                        if (!dc.ready) begin
                            r_state <= BUSY;
                        end else if (fc_stall_i) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (fc_flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (dc.ready) begin
                        r_state <= IDLE;
                        if (fc_stall_i) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if ((w_idle && fc_flush_i) || (w_idle && !r_done && !ex_mem_reg_valid_i)) begin
                mem_wb_reg_op_c_o      <= '0;
                mem_wb_reg_reg_waddr_o <= '0;
                mem_wb_reg_reg_we_o    <= 1'b0;
                mem_wb_reg_mtype_o     <= 1'b0;
                mem_wb_reg_width_o     <= '0;
                r_done                 <= 1'b0;
            end else if (!(fc_stall_i || mem_stall_o)) begin
                if (!w_idle || r_done) begin
                    mem_wb_reg_op_c_o      <= r_req.addr;
                    mem_wb_reg_reg_waddr_o <= r_waddr;
                    mem_wb_reg_reg_we_o    <= r_reg_we & ~r_req.we & ~(r_kill | fc_flush_i);
                    mem_wb_reg_mtype_o     <= r_mtype;
                    mem_wb_reg_width_o     <= r_width;
                    r_done                 <= 1'b0;
                    r_kill                 <= 1'b0;
                end else begin
                    mem_wb_reg_op_c_o      <= ex_mem_reg_op_c_i;
                    mem_wb_reg_reg_waddr_o <= ex_mem_reg_reg_waddr_i;
                    mem_wb_reg_reg_we_o    <= ex_mem_reg_reg_we_i & ~w_is_store & ~w_mis_access;
                    mem_wb_reg_mtype_o     <= w_is_load & ~w_mis_access;
                    mem_wb_reg_width_o     <= ex_mem_reg_width_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle accesses plus
// hand-written stall / flush / reset sequences, mem_wb checked via scoreboard.
module tb_mem_stage;
    import core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_op_c;
    logic [31:0] ex_op_b;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_width;
    logic        fc_stall;
    logic        fc_flush;
    logic        mem_stall;
    logic        mem_misalign;
    logic [31:0] wb_op_c;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic        wb_mtype;
    logic [1:0]  wb_width;

    mem_stage_if dc ();

    mem_stage dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ex_mem_reg_valid_i     (ex_valid),
        .ex_mem_reg_op_c_i      (ex_op_c),
        .ex_mem_reg_op_b_i      (ex_op_b),
        .ex_mem_reg_reg_waddr_i (ex_waddr),
        .ex_mem_reg_reg_we_i    (ex_we),
        .ex_mem_reg_mem_op_i    (ex_mem_op),
        .ex_mem_reg_width_i     (ex_width),
        .fc_stall_i             (fc_stall),
        .fc_flush_i             (fc_flush),
        .dc                     (dc),
        .mem_stall_o            (mem_stall),
        .mem_misalign_o         (mem_misalign),
        .mem_wb_reg_op_c_o      (wb_op_c),
        .mem_wb_reg_reg_waddr_o (wb_waddr),
        .mem_wb_reg_reg_we_o    (wb_we),
        .mem_wb_reg_mtype_o     (wb_mtype),
        .mem_wb_reg_width_o     (wb_width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op_c;
        logic [4:0]  waddr;
        logic        we;
        logic        mtype;
        logic [1:0]  width;
    } mwb_t;

    typedef struct {
        string       name;
        logic [31:0] op_c;
        logic [31:0] op_b;
        logic [1:0]  mem_op;
        logic [1:0]  width;
        logic        reg_we;
        logic [4:0]  waddr;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    mwb_t sb[$];
    vec_t vecs[14];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] op_c, input logic [31:0] op_b,
                         input logic [4:0] waddr, input logic we, input logic [1:0] mem_op,
                         input logic [1:0] width);
        ex_valid  = v;
        ex_op_c   = op_c;
        ex_op_b   = op_b;
        ex_waddr  = waddr;
        ex_we     = we;
        ex_mem_op = mem_op;
        ex_width  = width;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic push(input logic [31:0] op_c, input logic [4:0] waddr, input logic we,
                        input logic mtype, input logic [1:0] width);
        mwb_t e;
        e.op_c  = op_c;
        e.waddr = waddr;
        e.we    = we;
        e.mtype = mtype;
        e.width = width;
        sb.push_back(e);
    endtask

    // Pop the oldest expected mem_wb entry and compare against the DUT outputs
    task automatic sb_check(input string tag);
        mwb_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, got op_c 0x%08h expected an entry", tag, wb_op_c);
        end else begin
            e = sb.pop_front();
            chk({tag, ".wb_op_c"},  wb_op_c,         e.op_c);
            chk({tag, ".wb_waddr"}, 32'(wb_waddr),   32'(e.waddr));
            chk({tag, ".wb_we"},    32'(wb_we),      32'(e.we));
            chk({tag, ".wb_mtype"}, 32'(wb_mtype),   32'(e.mtype));
            chk({tag, ".wb_width"}, 32'(wb_width),   32'(e.width));
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"st_b_1003",  32'h1003, 32'h0000_00AB, 2'b10, 2'b00, 1'b1, 5'd1, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0};
        vecs[1]  = '{"st_h_1002",  32'h1002, 32'h0000_1234, 2'b10, 2'b01, 1'b1, 5'd2, 1'b1, 4'b1100, 32'h1234_1234, 1'b0};
        vecs[2]  = '{"st_w_3004",  32'h3004, 32'hDEAD_BEEF, 2'b10, 2'b10, 1'b0, 5'd3, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{"st_b_1000",  32'h1000, 32'h1234_5655, 2'b10, 2'b00, 1'b1, 5'd4, 1'b1, 4'b0001, 32'h5555_5555, 1'b0};
        vecs[4]  = '{"st_h_1001",  32'h1001, 32'h0000_1234, 2'b10, 2'b01, 1'b1, 5'd5, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[5]  = '{"ld_w_2000",  32'h2000, 32'h0,         2'b01, 2'b10, 1'b1, 5'd6, 1'b1, 4'b0000, 32'h0,         1'b0};
        vecs[6]  = '{"ld_h_2002",  32'h2002, 32'h0,         2'b01, 2'b01, 1'b1, 5'd7, 1'b1, 4'b0000, 32'h0,         1'b0};
        vecs[7]  = '{"ld_w_2001",  32'h2001, 32'h0,         2'b01, 2'b10, 1'b1, 5'd8, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[8]  = '{"ld_b_2003",  32'h2003, 32'h0,         2'b01, 2'b00, 1'b1, 5'd9, 1'b1, 4'b0000, 32'h0,         1'b0};
        vecs[9]  = '{"alu_5",      32'h0005, 32'h0,         2'b00, 2'b10, 1'b1, 5'd3, 1'b0, 4'b0000, 32'h0,         1'b0};
        vecs[10] = '{"rsvd_op",    32'h2001, 32'h0,         2'b11, 2'b10, 1'b1, 5'd10, 1'b0, 4'b0000, 32'h0,        1'b0};
        vecs[11] = '{"ld_rsvd_w",  32'h2000, 32'h0,         2'b01, 2'b11, 1'b1, 5'd11, 1'b0, 4'b0000, 32'h0,        1'b1};
        vecs[12] = '{"st_w_3002",  32'h3002, 32'h0000_0001, 2'b10, 2'b10, 1'b1, 5'd12, 1'b0, 4'b0000, 32'h0,        1'b1};
        vecs[13] = '{"st_h_1000",  32'h1000, 32'hFFFF_BEEF, 2'b10, 2'b01, 1'b1, 5'd13, 1'b1, 4'b0011, 32'hBEEF_BEEF, 1'b0};

        // Reset with a valid load presented: nothing may leave the stage
        rst_n    = 1'b0;
        fc_stall = 1'b0;
        fc_flush = 1'b0;
        dc.ready = 1'b1;
        drive(1'b1, 32'h2000, 32'h0, 5'd1, 1'b1, 2'b01, 2'b10);
        #3;
        chk("rst.req",      32'(dc.req),       32'd0);
        chk("rst.stall",    32'(mem_stall),    32'd0);
        chk("rst.misalign", 32'(mem_misalign), 32'd0);
        chk("rst.wb_op_c",  wb_op_c,           32'd0);
        chk("rst.wb_we",    32'(wb_we),        32'd0);
        chk("rst.wb_mtype", 32'(wb_mtype),     32'd0);
        drive_idle();
        #9;
        rst_n = 1'b1;
        next_edge();

        // Single-cycle accesses with the Dcache always ready
        for (int i = 0; i < 14; i++) begin
            vec_t v;
            v = vecs[i];
            drive(1'b1, v.op_c, v.op_b, v.waddr, v.reg_we, v.mem_op, v.width);
            dc.ready = 1'b1;
            push(v.op_c, v.waddr,
                 v.reg_we & (v.mem_op != 2'b10) & ~v.exp_mis,
                 (v.mem_op == 2'b01) & ~v.exp_mis,
                 v.width);
            #4;
            chk({v.name, ".req"},      32'(dc.req),       32'(v.exp_req));
            chk({v.name, ".misalign"}, 32'(mem_misalign), 32'(v.exp_mis));
            chk({v.name, ".stall"},    32'(mem_stall),    32'd0);
            if (v.exp_req) begin
                chk({v.name, ".we"},   32'(dc.we),  32'(v.mem_op == 2'b10));
                chk({v.name, ".addr"}, dc.addr,     v.op_c);
                chk({v.name, ".be"},   32'(dc.be),  32'(v.exp_be));
                if (v.mem_op == 2'b10) begin
                    chk({v.name, ".wdata"}, dc.wdata, v.exp_wdata);
                end
            end
            next_edge();
            sb_check(v.name);
        end

        // Load held off by the Dcache for three cycles
        drive_idle();
        push(32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
        next_edge();
        sb_check("bubble_a");
        drive(1'b1, 32'h2000, 32'h0, 5'd7, 1'b1, 2'b01, 2'b10);
        dc.ready = 1'b0;
        push(32'h2000, 5'd7, 1'b1, 1'b1, 2'b10);
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("ldstall.c%0d.stall", c), 32'(mem_stall), 32'd1);
            chk($sformatf("ldstall.c%0d.req", c),   32'(dc.req),    32'd1);
            chk($sformatf("ldstall.c%0d.addr", c),  dc.addr,        32'h2000);
            chk($sformatf("ldstall.c%0d.be", c),    32'(dc.be),     32'd0);
            next_edge();
            chk($sformatf("ldstall.c%0d.wb_we", c), 32'(wb_we),     32'd0);
            // unrelated upstream data must not disturb the held request
            drive(1'b1, 32'hBAD0, 32'h0, 5'd31, 1'b1, 2'b00, 2'b10);
        end
        dc.ready = 1'b1;
        #4;
        chk("ldstall.accept.stall", 32'(mem_stall), 32'd0);
        chk("ldstall.accept.req",   32'(dc.req),    32'd1);
        chk("ldstall.accept.addr",  dc.addr,        32'h2000);
        next_edge();
        sb_check("ldstall");
        drive_idle();
        next_edge();

        // Flush while BUSY: request stays up, result is not written back
        drive(1'b1, 32'h4000, 32'h0, 5'd9, 1'b1, 2'b01, 2'b10);
        dc.ready = 1'b0;
        #4;
        chk("flush.stall0", 32'(mem_stall), 32'd1);
        next_edge();
        fc_flush = 1'b1;
        #4;
        chk("flush.req_held", 32'(dc.req), 32'd1);
        chk("flush.addr",     dc.addr,     32'h4000);
        next_edge();
        fc_flush = 1'b0;
        drive_idle();
        dc.ready = 1'b1;
        #4;
        chk("flush.req_accept", 32'(dc.req), 32'd1);
        chk("flush.addr2",      dc.addr,     32'h4000);
        next_edge();
        chk("flush.wb_we",    32'(wb_we),   32'd0);
        #4;
        chk("flush.req_done", 32'(dc.req),  32'd0);
        next_edge();

        // Acceptance under fc stall: no second request, mem_wb waits for release
        drive(1'b1, 32'h5000, 32'h0, 5'd12, 1'b1, 2'b01, 2'b10);
        fc_stall = 1'b1;
        #4;
        chk("stallacc.req",   32'(dc.req),    32'd1);
        chk("stallacc.stall", 32'(mem_stall), 32'd0);
        next_edge();
        chk("stallacc.wb_hold_we",   32'(wb_we), 32'd0);
        chk("stallacc.wb_hold_op_c", wb_op_c,    32'd0);
        #4;
        chk("stallacc.no_rereq", 32'(dc.req), 32'd0);
        next_edge();
        fc_stall = 1'b0;
        push(32'h5000, 5'd12, 1'b1, 1'b1, 2'b10);
        #4;
        chk("stallacc.no_rereq2", 32'(dc.req), 32'd0);
        next_edge();
        sb_check("stallacc");
        drive_idle();
        next_edge();

        // Asynchronous reset in the middle of a BUSY request
        drive(1'b1, 32'h0000_0077, 32'h0, 5'd4, 1'b1, 2'b00, 2'b10);
        next_edge();
        chk("rstbusy.pre_wb", wb_op_c, 32'h77);
        drive(1'b1, 32'h6000, 32'h0, 5'd5, 1'b1, 2'b01, 2'b10);
        dc.ready = 1'b0;
        #4;
        chk("rstbusy.stall", 32'(mem_stall), 32'd1);
        next_edge();
        chk("rstbusy.wb_held", wb_op_c, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstbusy.req",      32'(dc.req),       32'd0);
        chk("rstbusy.stall0",   32'(mem_stall),    32'd0);
        chk("rstbusy.misalign", 32'(mem_misalign), 32'd0);
        chk("rstbusy.wb_op_c",  wb_op_c,           32'd0);
        chk("rstbusy.wb_we",    32'(wb_we),        32'd0);
        drive(1'b1, 32'h0000_0005, 32'h0, 5'd3, 1'b1, 2'b00, 2'b10);
        dc.ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h5, 5'd3, 1'b1, 1'b0, 2'b10);
        next_edge();
        sb_check("post_rst_alu");
        drive_idle();
        next_edge();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
